rec_pwm_decoder: RTL and testbench

Measures the high time of one RC-receiver PWM channel in microseconds and converts it to the 0–250 receiver value consumed by the flight mode selector and the other channel consumers. One instance per receiver channel. It sits between the receiver input pin and the downstream `REC_VAL_BIT_WIDTH` value bus. It validates pulse width and, optionally, flags signal loss.

---
 rtl/rec_pwm_decoder_pkg.sv | 42 ++++
 rtl/rec_pwm_decoder_input_synchronizer.sv | 41 ++++
 rtl/rec_pwm_decoder.sv | 133 +++++++++++++
 tb/tb_rec_pwm_decoder.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/rec_pwm_decoder_pkg.sv
// ============================================================================
// Module  : rec_pwm_decoder_pkg
// Brief   : Shared widths, scaling endpoints and FSM encodings for the RC decoder
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package rec_pwm_decoder_pkg;

  localparam int REC_VAL_BIT_WIDTH = 8;

  localparam logic [15:0] SCALE_MIN_US = 16'd1000;
  localparam logic [15:0] SCALE_MAX_US = 16'd2000;

  typedef enum logic [1:0] {
    ST_WAIT_LOW  = 2'd0,
    ST_WAIT_RISE = 2'd1,
    ST_MEASURE   = 2'd2,
    ST_DISCARD   = 2'd3
  } state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

  // (clamp(width, 1000, 2000) - 1000) >> 2, always within 0..250
  function automatic logic [REC_VAL_BIT_WIDTH-1:0] scale_width(input logic [15:0] width);
    logic [15:0] clamped;
    logic [10:0] offset;
    if (width < SCALE_MIN_US)
      clamped = SCALE_MIN_US;
    else if (width > SCALE_MAX_US)
      clamped = SCALE_MAX_US;
    else
      clamped = width;
    offset = 11'(clamped - SCALE_MIN_US);
    return REC_VAL_BIT_WIDTH'(offset >> 2);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rec_pwm_decoder_input_synchronizer.sv
// ============================================================================
// Module  : rec_pwm_decoder_input_synchronizer
// Brief   : 2-flop synchronizer with registered rise/fall strobes, reusable per channel
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rec_pwm_decoder_input_synchronizer (
  input  logic us_clk,
  input  logic resetn,
  input  logic async_in,
  output logic sync_level,
  output logic rise,
  output logic fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      r_meta <= async_in;
      r_sync <= r_meta;
      r_prev <= r_sync;
      rise   <= r_sync & ~r_prev;
      fall   <= ~r_sync & r_prev;
    end
  end

  assign sync_level = r_sync;

endmodule

`default_nettype wire

// File: rtl/rec_pwm_decoder.sv
// ============================================================================
// Module  : rec_pwm_decoder
// Brief   : Measures RC PWM high time (1 us/clk) and maps it to a 0..250 value.
//           Optional signal-loss failsafe enabled by defining REC_FAILSAFE_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rec_pwm_decoder
  import rec_pwm_decoder_pkg::*;
#(
  parameter int unsigned                   MIN_PULSE_US = 900,
  parameter int unsigned                   MAX_PULSE_US = 2100,
  parameter logic [REC_VAL_BIT_WIDTH-1:0]  FAILSAFE_VAL = '0,
  parameter int unsigned                   TIMEOUT_US   = 50000
) (
  input  logic                         us_clk,
  input  logic                         resetn,
  input  logic                         pwm_in,
  output logic [REC_VAL_BIT_WIDTH-1:0] rec_val,
  output logic                         rec_valid,
  output logic                         pulse_err,
  output logic                         signal_lost
);

  localparam logic [15:0] c_min_pulse = 16'(MIN_PULSE_US);
  localparam logic [15:0] c_max_pulse = 16'(MAX_PULSE_US);
  // Low samples required after reset before a rise may be trusted; covers the
  // synchronizer flushing out its reset zeros.
  localparam logic [15:0] c_settle    = 16'd3;

  state_t      r_state;
  logic [15:0] r_count;
  logic        w_sync;
  logic        w_rise;
  logic        w_fall;
  logic        w_accept;
  logic        w_reject;

  rec_pwm_decoder_input_synchronizer u_sync (
    .us_clk     (us_clk),
    .resetn     (resetn),
    .async_in   (pwm_in),
    .sync_level (w_sync),
    .rise       (w_rise),
    .fall       (w_fall)
  );

  assign w_accept = w_fall && (r_state == ST_MEASURE) && (r_count >= c_min_pulse);
  assign w_reject = w_fall && (((r_state == ST_MEASURE) && (r_count < c_min_pulse)) ||
                               (r_state == ST_DISCARD));

`ifdef REC_FAILSAFE_EN
  localparam logic [15:0] c_timeout_m1 = 16'(TIMEOUT_US - 1);
  logic [15:0] r_silence;
  logic        r_fs_fired;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{FAILSAFE_VAL, 32'(TIMEOUT_US)};
  assign signal_lost  = 1'b0;
`endif

  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= ST_WAIT_LOW;
      r_count   <= '0;
      rec_val   <= '0;
      rec_valid <= 1'b0;
      pulse_err <= 1'b0;
`ifdef REC_FAILSAFE_EN
      r_silence   <= '0;
      r_fs_fired  <= 1'b0;
      signal_lost <= 1'b1;
`endif
    end else begin
      rec_valid <= w_accept;
      pulse_err <= w_reject;
      if (w_accept)
        rec_val <= scale_width(r_count);

      case (r_state)
        ST_WAIT_LOW: begin
          if (w_sync)
            r_count <= '0;
          else if (r_count >= c_settle)
            r_state <= ST_WAIT_RISE;
          else
            r_count <= r_count + 16'd1;
        end
        ST_WAIT_RISE: begin
          if (w_rise) begin
            r_count <= 16'd1;
            r_state <= ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          if (w_fall)
            r_state <= ST_WAIT_RISE;
          else if (r_count > c_max_pulse)
            r_state <= ST_DISCARD;
          else
            r_count <= sat_inc16(r_count);
        end
        ST_DISCARD: begin
          if (w_fall)
            r_state <= ST_WAIT_RISE;
        end
        default: r_state <= ST_WAIT_LOW;
      endcase

`ifdef REC_FAILSAFE_EN
      // An accepted pulse beats a coinciding timeout; a reject defers it a cycle
      // so rec_valid and pulse_err never overlap.
      if (w_accept) begin
        r_silence   <= '0;
        r_fs_fired  <= 1'b0;
        signal_lost <= 1'b0;
      end else begin
        r_silence <= sat_inc16(r_silence);
        if (!w_reject && !r_fs_fired && (r_silence >= c_timeout_m1)) begin
          r_fs_fired  <= 1'b1;
          signal_lost <= 1'b1;
          rec_val     <= FAILSAFE_VAL;
          rec_valid   <= 1'b1;
        end
      end
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rec_pwm_decoder.sv
// ============================================================================
// Module  : tb_rec_pwm_decoder
// Brief   : Directed self-checking bench for rec_pwm_decoder
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rec_pwm_decoder;

  logic       us_clk;
  logic       resetn;
  logic       pwm_in;
  logic [7:0] rec_val;
  logic       rec_valid;
  logic       pulse_err;
  logic       signal_lost;

  int checks    = 0;
  int failures  = 0;
  int n_valid   = 0;
  int n_err     = 0;
  int n_overlap = 0;

`ifdef REC_FAILSAFE_EN
  localparam logic c_lost_rst = 1'b1;
`else
  localparam logic c_lost_rst = 1'b0;
`endif

  rec_pwm_decoder dut (
    .us_clk      (us_clk),
    .resetn      (resetn),
    .pwm_in      (pwm_in),
    .rec_val     (rec_val),
    .rec_valid   (rec_valid),
    .pulse_err   (pulse_err),
    .signal_lost (signal_lost)
  );

  initial us_clk = 1'b0;
  always #5 us_clk = ~us_clk;

  always @(negedge us_clk) begin
    if (rec_valid) n_valid++;
    if (pulse_err) n_err++;
    if (rec_valid && pulse_err) n_overlap++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drives a pulse of exactly w high samples, then checks the N+3 result.
  task automatic pulse(input int w, input logic exp_valid, input logic exp_err,
                       input logic [7:0] exp_val);
    string tag;
    tag = $sformatf("pulse%0d", w);
    @(negedge us_clk) pwm_in = 1'b1;
    repeat (w) @(negedge us_clk);
    pwm_in = 1'b0;
    @(posedge us_clk);
    for (int k = 1; k <= 2; k++) begin
      @(posedge us_clk); #1;
      chk({tag, "_early_valid"}, 32'(rec_valid), 32'd0);
      chk({tag, "_early_err"}, 32'(pulse_err), 32'd0);
    end
    @(posedge us_clk); #1;
    chk({tag, "_valid"}, 32'(rec_valid), 32'(exp_valid));
    chk({tag, "_err"}, 32'(pulse_err), 32'(exp_err));
    chk({tag, "_val"}, 32'(rec_val), 32'(exp_val));
    @(posedge us_clk); #1;
    chk({tag, "_valid_drop"}, 32'(rec_valid), 32'd0);
    chk({tag, "_err_drop"}, 32'(pulse_err), 32'd0);
    repeat (10) @(negedge us_clk);
  endtask

  initial begin
    int v0;
    int e0;
    resetn = 1'b0;
    pwm_in = 1'b0;
    repeat (3) @(negedge us_clk);
    chk("rst_val", 32'(rec_val), 32'd0);
    chk("rst_valid", 32'(rec_valid), 32'd0);
    chk("rst_err", 32'(pulse_err), 32'd0);
    chk("rst_lost", 32'(signal_lost), 32'(c_lost_rst));
    resetn = 1'b1;
    repeat (10) @(negedge us_clk);

    pulse(1500, 1'b1, 1'b0, 8'd125);
    pulse(1000, 1'b1, 1'b0, 8'd0);
    pulse(2000, 1'b1, 1'b0, 8'd250);
    pulse(950,  1'b1, 1'b0, 8'd0);
    pulse(2050, 1'b1, 1'b0, 8'd250);
    pulse(1500, 1'b1, 1'b0, 8'd125);
    pulse(800,  1'b0, 1'b1, 8'd125);
    pulse(2300, 1'b0, 1'b1, 8'd125);
    pulse(899,  1'b0, 1'b1, 8'd125);
    pulse(900,  1'b1, 1'b0, 8'd0);
    pulse(1004, 1'b1, 1'b0, 8'd1);
    pulse(1999, 1'b1, 1'b0, 8'd249);
    pulse(2100, 1'b1, 1'b0, 8'd250);

    // Back-to-back pulses separated by a single low sample
    v0 = n_valid;
    @(negedge us_clk) pwm_in = 1'b1;
    repeat (1500) @(negedge us_clk);
    pwm_in = 1'b0;
    @(negedge us_clk) pwm_in = 1'b1;
    repeat (1200) @(negedge us_clk);
    pwm_in = 1'b0;
    repeat (20) @(negedge us_clk);
    chk("b2b_count", 32'(n_valid - v0), 32'd2);
    chk("b2b_val", 32'(rec_val), 32'd50);

    // Reset 300 us into a 1500 us pulse
    pulse(1500, 1'b1, 1'b0, 8'd125);
    v0 = n_valid;
    e0 = n_err;
    @(negedge us_clk) pwm_in = 1'b1;
    repeat (300) @(negedge us_clk);
    resetn = 1'b0;
    #1;
    chk("midrst_val", 32'(rec_val), 32'd0);
    chk("midrst_lost", 32'(signal_lost), 32'(c_lost_rst));
    repeat (2) @(negedge us_clk);
    resetn = 1'b1;
    repeat (1198) @(negedge us_clk);
    pwm_in = 1'b0;
    repeat (20) @(negedge us_clk);
    chk("midrst_no_valid", 32'(n_valid - v0), 32'd0);
    chk("midrst_no_err", 32'(n_err - e0), 32'd0);
    pulse(1200, 1'b1, 1'b0, 8'd50);

`ifdef REC_FAILSAFE_EN
    chk("fs_lost_after_pulse", 32'(signal_lost), 32'd0);
    v0 = n_valid;
    repeat (50010) @(negedge us_clk);
    chk("fs_lost", 32'(signal_lost), 32'd1);
    chk("fs_val", 32'(rec_val), 32'd0);
    chk("fs_single_valid", 32'(n_valid - v0), 32'd1);
    pulse(1500, 1'b1, 1'b0, 8'd125);
    chk("fs_recovered", 32'(signal_lost), 32'd0);
`else
    chk("lost_tied_low", 32'(signal_lost), 32'd0);
`endif

    chk("no_overlap", 32'(n_overlap), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
